// File: rtl/branch_sequencer.sv
// Instruction-fetch / control-flow sequencer: owns the PC, fetches over valid/ready and traps stack and fetch faults.
// Optional fetch watchdog (fault code 11) is compiled in when BRANCH_SEQ_TIMEOUT_EN is defined.
module branch_sequencer #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 32,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] bc_instr,
    output logic [ADDR_W-1:0] ret_addr,
    input  logic [DATA_W-1:0] bc_r_abs,
    input  logic              bc_full,
    input  logic              bc_empty,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fault,
    output logic [1:0]        fault_code
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_BRANCH, S_FAULT} state_t;

    localparam logic [4:0] OP_JR   = 5'b01101;
    localparam logic [4:0] OP_JPC  = 5'b01110;
    localparam logic [4:0] OP_CALL = 5'b10000;
    localparam logic [4:0] OP_RET  = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [DATA_W-1:0] instr_q, instr_n;
    logic              halted_q, halted_n;
    logic [1:0]        code_q, code_n;
    logic [4:0]        op;
    logic              is_branch;

    // Only the low ADDR_W bits of the branch target are meaningful.
    logic              r_abs_hi_unused;
    assign r_abs_hi_unused = ^bc_r_abs[DATA_W-1:ADDR_W];

`ifdef BRANCH_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [1:0] FC_TMO = 2'b11;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(FETCH_TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(FETCH_TIMEOUT);
`endif

    assign op        = instr_q[DATA_W-1 -: 5];
    assign is_branch = (op == OP_JR) || (op == OP_JPC) || (op == OP_CALL) || (op == OP_RET);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            halted_q <= 1'b0;
            code_q   <= 2'b00;
`ifdef BRANCH_SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            instr_q  <= instr_n;
            halted_q <= halted_n;
            code_q   <= code_n;
`ifdef BRANCH_SEQ_TIMEOUT_EN
            wait_cnt <= wait_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc_q;
        instr_n     = instr_q;
        halted_n    = halted_q;
        code_n      = code_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        bc_instr    = '0;
`ifdef BRANCH_SEQ_TIMEOUT_EN
        // Counter idles at zero outside FETCH, so every FETCH entry starts a fresh window.
        wait_cnt_n  = '0;
`endif
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pc_n     = boot_addr;
                    halted_n = 1'b0;
                    state_n  = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_n = imem_rdata;
                    state_n = S_ISSUE;
                end
`ifdef BRANCH_SEQ_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    code_n  = FC_TMO;
                    state_n = S_FAULT;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
`endif
            end
            S_ISSUE: begin
                if (!stall) begin
                    instr_valid = 1'b1;
                    // Trapping CALL/RET keep bc_instr at NOP so the return stack is untouched.
                    if (op == OP_CALL && bc_full) begin
                        code_n  = FC_OVF;
                        state_n = S_FAULT;
                    end else if (op == OP_RET && bc_empty) begin
                        code_n  = FC_UNF;
                        state_n = S_FAULT;
                    end else begin
                        bc_instr = instr_q;
                        if (is_branch) begin
                            state_n = S_BRANCH;
                        end else if (op == OP_HALT) begin
                            halted_n = 1'b1;
                            state_n  = S_IDLE;
                        end else begin
                            pc_n    = pc_q + ADDR_W'(1);
                            state_n = S_FETCH;
                        end
                    end
                end
            end
            S_BRANCH: begin
                pc_n    = bc_r_abs[ADDR_W-1:0];
                state_n = S_FETCH;
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign ret_addr   = pc_q + ADDR_W'(1);
    assign instr      = instr_q;
    assign halted     = halted_q;
    assign fault      = (state == S_FAULT);
    assign fault_code = code_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: memory/branch-controller stubs, directed scenarios and a randomized
// program run checked against a program-level model of the fetch/branch/stack rules.
module tb_branch_sequencer;
    localparam int AW = 15, DW = 32, DEPTH = 4;
    localparam logic [4:0] OP_JR = 5'b01101, OP_JPC = 5'b01110, OP_CALL = 5'b10000,
                           OP_RET = 5'b10001, OP_HALT = 5'b11111;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, stall = 1'b0, imem_ready = 1'b0;
    logic bc_full = 1'b0, bc_empty = 1'b1;
    logic [AW-1:0] boot_addr = '0;
    logic [DW-1:0] imem_rdata = '0, bc_r_abs = '0;
    logic imem_req, instr_valid, halted, fault;
    logic [AW-1:0] imem_addr, ret_addr, pc;
    logic [DW-1:0] instr, bc_instr;
    logic [1:0] fault_code;

    int total = 0, bad = 0;
    int ready_pct = 100, stall_pct = 0;
    bit ready_force = 0, stall_force = 0, force_full = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] stk[$];
    int pend = 0;
    logic [AW-1:0] pend_addr;
    logic [4:0] bop;

    logic [AW-1:0] mon_pc[$], mon_fetch[$];
    logic [DW-1:0] mon_ins[$];
    int bc_nz = 0;

    logic [AW-1:0] exp_pc[$];
    logic [DW-1:0] exp_ins[$];
    int exp_end;
    logic [1:0] exp_code;
    logic [AW-1:0] exp_last_pc;

    branch_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .boot_addr(boot_addr), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .bc_instr(bc_instr), .ret_addr(ret_addr),
        .bc_r_abs(bc_r_abs), .bc_full(bc_full), .bc_empty(bc_empty), .pc(pc),
        .halted(halted), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Memory responder and return-stack branch controller, driven just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                stk.delete();
                pend = 0;
            end else if (pend == 1) begin
                if (stk.size() < DEPTH) stk.push_back(pend_addr);
            end else if (pend == 2) begin
                if (stk.size() > 0) void'(stk.pop_back());
            end
            pend = 0;
            bc_full  = force_full || (stk.size() == DEPTH);
            bc_empty = (stk.size() == 0);
            stall = stall_force || ($urandom_range(0, 99) < stall_pct);
            imem_ready = ready_force || (imem_req && ($urandom_range(0, 99) < ready_pct));
            imem_rdata = imem_req ? mem[imem_addr] : 32'hDEAD_BEEF;
            #1;
            if (bc_instr != '0) begin
                bop = bc_instr[31:27];
                bc_r_abs = $urandom();
                if (bop == OP_CALL) begin
                    pend = 1;
                    pend_addr = ret_addr;
                    bc_r_abs[AW-1:0] = bc_instr[AW-1:0];
                end else if (bop == OP_RET) begin
                    pend = 2;
                    if (stk.size() > 0) bc_r_abs[AW-1:0] = stk[$];
                end else if (bop == OP_JR || bop == OP_JPC) begin
                    bc_r_abs[AW-1:0] = bc_instr[AW-1:0];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (instr_valid) begin
                mon_pc.push_back(pc);
                mon_ins.push_back(instr);
            end
            if (imem_req && imem_ready) mon_fetch.push_back(imem_addr);
            if (bc_instr != '0) bc_nz++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input logic [4:0] o, input logic [AW-1:0] t);
        logic [11:0] mid;
        mid = 12'($urandom());
        return {o, mid, t};
    endfunction

    function automatic logic [4:0] seq_op();
        logic [4:0] o;
        do o = 5'($urandom());
        while (o == OP_JR || o == OP_JPC || o == OP_CALL || o == OP_RET || o == OP_HALT);
        return o;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; ready_force = 0; stall_force = 0; force_full = 0;
        stall_pct = 0; ready_pct = 100;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_pc.delete(); mon_ins.delete(); mon_fetch.delete(); bc_nz = 0;
    endtask

    // Called right after a falling edge; returns in the first cycle after start is taken.
    task automatic pulse_start(input logic [AW-1:0] a);
        boot_addr = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Program-level model: walks the program with an explicit return stack.
    task automatic model_run(input logic [AW-1:0] boot);
        logic [AW-1:0] p, s[$];
        logic [DW-1:0] w;
        logic [4:0] o;
        p = boot;
        exp_pc.delete(); exp_ins.delete();
        exp_end = 0; exp_code = 2'b00;
        for (int n = 0; n < 40; n++) begin
            w = mem[p];
            o = w[31:27];
            exp_pc.push_back(p);
            exp_ins.push_back(w);
            if (o == OP_CALL) begin
                if (s.size() == DEPTH) begin exp_end = 2; exp_code = 2'b01; break; end
                s.push_back(p + 15'd1);
                p = w[AW-1:0];
            end else if (o == OP_RET) begin
                if (s.size() == 0) begin exp_end = 2; exp_code = 2'b10; break; end
                p = s.pop_back();
            end else if (o == OP_JR || o == OP_JPC) begin
                p = w[AW-1:0];
            end else if (o == OP_HALT) begin
                exp_end = 1;
                break;
            end else begin
                p = p + 15'd1;
            end
        end
        exp_last_pc = p;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
        total++; if (imem_addr !== 15'h0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
        total++; if (pc !== 15'h0) begin bad++; $display("FAIL rst_pc got=%0h exp=0", pc); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%0h exp=0", instr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
        total++; if (bc_instr !== 32'h0) begin bad++; $display("FAIL rst_bc_instr got=%0h exp=0", bc_instr); end
        total++; if (ret_addr !== 15'h1) begin bad++; $display("FAIL rst_ret_addr got=%0h exp=1", ret_addr); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%0h exp=0", halted); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%0h exp=0", fault); end
        total++; if (fault_code !== 2'b00) begin bad++; $display("FAIL rst_code got=%0h exp=0", fault_code); end
    endtask

    // Zero-wait memory with ready already high at start; HALT at the end of the run.
    task automatic test_sequential();
        logic [AW-1:0] ea;
        do_reset(); clear_mem();
        for (int i = 0; i < 3; i++) mem[16 + i] = mk(seq_op(), 15'($urandom()));
        mem[19] = mk(OP_HALT, 15'h0);
        ready_force = 1;
        pulse_start(15'h10);
        for (int k = 1; k <= 8; k++) begin
            ea = 15'(16 + (k - 1) / 2);
            total++; if (imem_req !== 1'(k % 2)) begin bad++; $display("FAIL seq_req c%0d got=%0h exp=%0h", k, imem_req, k % 2); end
            total++; if (instr_valid !== 1'(1 - k % 2)) begin bad++; $display("FAIL seq_valid c%0d got=%0h exp=%0h", k, instr_valid, 1 - k % 2); end
            if (k % 2 == 1) begin
                total++; if (imem_addr !== ea) begin bad++; $display("FAIL seq_addr c%0d got=%0h exp=%0h", k, imem_addr, ea); end
            end else begin
                total++; if (instr !== mem[ea]) begin bad++; $display("FAIL seq_instr c%0d got=%0h exp=%0h", k, instr, mem[ea]); end
            end
            @(negedge clk);
        end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%0h exp=1", halted); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req got=%0h exp=0", imem_req); end
        total++; if (pc !== 15'h13) begin bad++; $display("FAIL halt_pc got=%0h exp=13", pc); end
        pulse_start(15'h10);
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL restart_halted got=%0h exp=0", halted); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 15'h10) begin bad++; $display("FAIL restart_fetch got=%0h/%0h exp=1/10", imem_req, imem_addr); end
        ready_force = 0;
    endtask

    task automatic test_call_ret();
        int n;
        do_reset(); clear_mem();
        mem[15'h20]  = mk(OP_CALL, 15'h100);
        mem[15'h100] = mk(OP_RET, 15'($urandom()));
        mem[15'h21]  = mk(OP_HALT, 15'h0);
        pulse_start(15'h20);
        @(negedge clk);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL call_valid got=%0h exp=1", instr_valid); end
        total++; if (ret_addr !== 15'h21) begin bad++; $display("FAIL call_ret_addr got=%0h exp=21", ret_addr); end
        total++; if (bc_instr !== mem[15'h20]) begin bad++; $display("FAIL call_bc_instr got=%0h exp=%0h", bc_instr, mem[15'h20]); end
        @(negedge clk);
        total++; if (bc_instr !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL call_branch got=%0h/%0h exp=0/0", bc_instr, imem_req); end
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 15'h100) begin bad++; $display("FAIL call_target got=%0h/%0h exp=1/100", imem_req, imem_addr); end
        @(negedge clk);
        total++; if (bc_instr !== mem[15'h100]) begin bad++; $display("FAIL ret_bc_instr got=%0h exp=%0h", bc_instr, mem[15'h100]); end
        repeat (2) @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 15'h21) begin bad++; $display("FAIL ret_target got=%0h/%0h exp=1/21", imem_req, imem_addr); end
        n = 0;
        while (!halted && n < 20) begin @(negedge clk); n++; end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL callret_halt_timeout got=%0h exp=1", halted); end
        total++; if (bc_nz !== 3) begin bad++; $display("FAIL callret_bc_cycles got=%0d exp=3", bc_nz); end
        total++; if (mon_fetch.size() !== 3) begin bad++; $display("FAIL callret_fetches got=%0d exp=3", mon_fetch.size()); end
    endtask

    task automatic test_stall();
        do_reset(); clear_mem();
        mem[15'h40] = mk(seq_op(), 15'($urandom()));
        mem[15'h41] = mk(OP_HALT, 15'h0);
        stall_force = 1;
        pulse_start(15'h40);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            total++; if (instr_valid !== 1'b0 || bc_instr !== 32'h0) begin bad++; $display("FAIL stall_hold c%0d got=%0h/%0h exp=0/0", j, instr_valid, bc_instr); end
            total++; if (pc !== 15'h40) begin bad++; $display("FAIL stall_pc c%0d got=%0h exp=40", j, pc); end
            if (j == 2) stall_force = 0;
            @(negedge clk);
        end
        total++; if (instr_valid !== 1'b1 || bc_instr !== mem[15'h40]) begin bad++; $display("FAIL stall_release got=%0h/%0h exp=1/%0h", instr_valid, bc_instr, mem[15'h40]); end
        @(negedge clk);
        total++; if (instr_valid !== 1'b0 || imem_addr !== 15'h41) begin bad++; $display("FAIL stall_single got=%0h/%0h exp=0/41", instr_valid, imem_addr); end
    endtask

    task automatic test_call_full();
        do_reset(); clear_mem();
        force_full = 1;
        mem[15'h30] = mk(OP_CALL, 15'h200);
        pulse_start(15'h30);
        @(negedge clk);
        total++; if (bc_instr !== 32'h0) begin bad++; $display("FAIL ovf_bc_instr got=%0h exp=0", bc_instr); end
        @(negedge clk);
        total++; if (fault !== 1'b1 || fault_code !== 2'b01) begin bad++; $display("FAIL ovf_fault got=%0h/%0h exp=1/1", fault, fault_code); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ovf_req got=%0h exp=0", imem_req); end
        pulse_start(15'h10);
        for (int j = 0; j < 3; j++) begin
            total++; if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 15'h30) begin bad++; $display("FAIL ovf_sticky c%0d got=%0h/%0h/%0h exp=1/0/30", j, fault, imem_req, pc); end
            @(negedge clk);
        end
        total++; if (bc_nz !== 0) begin bad++; $display("FAIL ovf_no_push got=%0d exp=0", bc_nz); end
        do_reset();
        total++; if (fault !== 1'b0 || fault_code !== 2'b00) begin bad++; $display("FAIL ovf_clear got=%0h/%0h exp=0/0", fault, fault_code); end
    endtask

    task automatic test_ret_empty();
        do_reset(); clear_mem();
        mem[15'h50] = mk(OP_RET, 15'h0);
        pulse_start(15'h50);
        @(negedge clk);
        total++; if (bc_instr !== 32'h0) begin bad++; $display("FAIL unf_bc_instr got=%0h exp=0", bc_instr); end
        @(negedge clk);
        total++; if (fault !== 1'b1 || fault_code !== 2'b10) begin bad++; $display("FAIL unf_fault got=%0h/%0h exp=1/2", fault, fault_code); end
    endtask

    task automatic test_wrap();
        do_reset(); clear_mem();
        mem[15'h7FFF] = mk(seq_op(), 15'h0);
        mem[15'h0000] = mk(OP_HALT, 15'h0);
        pulse_start(15'h7FFF);
        total++; if (ret_addr !== 15'h0) begin bad++; $display("FAIL wrap_ret_addr got=%0h exp=0", ret_addr); end
        repeat (2) @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 15'h0) begin bad++; $display("FAIL wrap_pc got=%0h/%0h exp=1/0", imem_req, imem_addr); end
    endtask

    task automatic test_timeout();
        do_reset(); clear_mem();
        mem[15'h60] = mk(OP_HALT, 15'h0);
        ready_pct = 0;
        pulse_start(15'h60);
`ifdef BRANCH_SEQ_TIMEOUT_EN
        repeat (14) @(negedge clk);
        total++; if (fault !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL tmo_early got=%0h/%0h exp=0/1", fault, imem_req); end
        @(negedge clk);
        total++; if (fault !== 1'b1 || fault_code !== 2'b11) begin bad++; $display("FAIL tmo_fault got=%0h/%0h exp=1/3", fault, fault_code); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL tmo_req got=%0h exp=0", imem_req); end
        do_reset();
        ready_pct = 0;
        pulse_start(15'h60);
        repeat (13) @(negedge clk);
        ready_force = 1;
        @(negedge clk);
        ready_force = 0;
        @(negedge clk);
        total++; if (instr_valid !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL tmo_ready_wins got=%0h/%0h exp=1/0", instr_valid, fault); end
`else
        repeat (19) @(negedge clk);
        total++; if (imem_req !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL notmo_wait got=%0h/%0h exp=1/0", imem_req, fault); end
        total++; if (fault_code !== 2'b00) begin bad++; $display("FAIL notmo_code got=%0h exp=0", fault_code); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset(); clear_mem();
        ready_pct = 0;
        mem[15'h70] = mk(seq_op(), 15'h0);
        pulse_start(15'h70);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ready_pct = 100;
        total++; if (imem_req !== 1'b0 || pc !== 15'h0 || imem_addr !== 15'h0) begin bad++; $display("FAIL midfetch_rst got=%0h/%0h/%0h exp=0/0/0", imem_req, pc, imem_addr); end
        total++; if (ret_addr !== 15'h1 || instr !== 32'h0) begin bad++; $display("FAIL midfetch_regs got=%0h/%0h exp=1/0", ret_addr, instr); end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midfetch_reissue c%0d got=%0h exp=0", j, imem_req); end
        end
        mem[15'h20] = mk(OP_CALL, 15'h100);
        pulse_start(15'h20);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++; if (pc !== 15'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL midbranch_rst got=%0h/%0h exp=0/0", pc, imem_req); end
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midbranch_reissue got=%0h exp=0", imem_req); end
    endtask

    task automatic test_random();
        logic [AW-1:0] base, a;
        int r, n, exp_n;
        for (int run = 0; run < 8; run++) begin
            do_reset(); clear_mem();
            base = (run % 2) ? 15'h7FF8 : 15'($urandom());
            for (int k = 0; k < 16; k++) begin
                a = base + 15'(k);
                r = $urandom_range(0, 99);
                if (r < 45)      mem[a] = mk(seq_op(), 15'($urandom()));
                else if (r < 55) mem[a] = mk(OP_JR, base + 15'($urandom_range(0, 15)));
                else if (r < 65) mem[a] = mk(OP_JPC, base + 15'($urandom_range(0, 15)));
                else if (r < 80) mem[a] = mk(OP_CALL, base + 15'($urandom_range(0, 15)));
                else if (r < 94) mem[a] = mk(OP_RET, 15'($urandom()));
                else             mem[a] = mk(OP_HALT, 15'h0);
            end
            ready_pct = $urandom_range(30, 100);
            stall_pct = $urandom_range(0, 40);
            model_run(base);
            exp_n = exp_pc.size();
            pulse_start(base);
            n = 0;
            while (mon_pc.size() < exp_n && n < 3000) begin @(negedge clk); n++; end
            total++; if (mon_pc.size() < exp_n) begin bad++; $display("FAIL rnd%0d_timeout got=%0d exp=%0d issues", run, mon_pc.size(), exp_n); end
            for (int i = 0; i < exp_n && i < mon_pc.size(); i++) begin
                total++; if (mon_pc[i] !== exp_pc[i] || mon_ins[i] !== exp_ins[i]) begin bad++; $display("FAIL rnd%0d_issue%0d got=%0h:%0h exp=%0h:%0h", run, i, mon_pc[i], mon_ins[i], exp_pc[i], exp_ins[i]); end
            end
            if (exp_end != 0) begin
                repeat (3) @(negedge clk);
                total++; if (mon_pc.size() !== exp_n) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", run, mon_pc.size(), exp_n); end
                total++; if (pc !== exp_last_pc) begin bad++; $display("FAIL rnd%0d_endpc got=%0h exp=%0h", run, pc, exp_last_pc); end
                if (exp_end == 1) begin
                    total++; if (halted !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL rnd%0d_halt got=%0h/%0h exp=1/0", run, halted, fault); end
                end else begin
                    total++; if (fault !== 1'b1 || fault_code !== exp_code) begin bad++; $display("FAIL rnd%0d_fault got=%0h/%0h exp=1/%0h", run, fault, fault_code, exp_code); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_call_ret();
        test_stall();
        test_call_full();
        test_ret_empty();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
